uart16550_csr: RTL and testbench
================================

# uart16550_csr

Parametrised 16550-compatible control/status register block: the next generation of the UART register file, adding interrupt enable/identification, sticky line-status errors with clear-on-read, FIFO threshold detection, scratch/modem registers and a configurable-width divisor. Sits between the host bus (wr_i/rd_i/addr_i) and the UART TX/RX datapaths and FIFOs, and drives the shared 16x baud pulse.

## Interface
- DIV_W, 16, divisor width (9..24); DLL holds bits 7:0, DLM holds bits DIV_W-1:8
- FIFO_DEPTH, 16, RX/TX FIFO depth; CNT_W = $clog2(FIFO_DEPTH+1)
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- wr_i / rd_i  in  1  host write / read strobes, one access per cycle each
- addr_i  in  3  register address
- din_i  in  8  write data
- dout_o  out  8  read data, registered
- rx_fifo_in  in  8  RX FIFO head data
- rx_fifo_empty_i, tx_fifo_empty_i  in  1  FIFO empty flags
- rx_fifo_count_i  in  CNT_W  RX FIFO occupancy
- rx_oe, rx_pe, rx_fe, rx_bi  in  1  one-cycle error pulses from RX
- tx_push_o, rx_pop_o  out  1  FIFO push/pop strobes
- tx_rst, rx_rst  out  1  one-cycle FIFO reset pulses
- rx_fifo_threshold  out  4  decoded trigger level
- baud_out  out  1  one-cycle baud pulse
- irq_o  out  1  interrupt request
- csr  out  csr_t  all register contents for datapaths

## Operation
- Address map (DLAB = LCR[7]): 0 RBR(rd)/THR(wr), DLL when DLAB; 1 IER[3:0], DLM when DLAB; 2 IIR(rd)/FCR(wr); 3 LCR; 4 MCR[4:0]; 5 LSR(rd only); 6 MSR (reads 0); 7 SCR.
- THR write: tx_push_o = wr_i & addr 0 & !DLAB, combinational, din_i goes to TX FIFO. RBR read: rx_pop_o = rd_i & addr 0 & !DLAB & !rx_fifo_empty_i; empty read returns 0x00, no pop.
- FCR: bit0 fifo enable stored; bits 1/2 produce rx_rst/tx_rst one-cycle pulses, never stored; bits 7:6 -> threshold 1/4/8/14 (clipped to FIFO_DEPTH).
- LSR: b0 = !rx_fifo_empty_i; b1..b4 = sticky OE/PE/FE/BI; b5 = tx_fifo_empty_i; b6 = tx_fifo_empty_i; b7 = OR of b1..b4. Sticky bits clear on LSR read; set in same cycle as clear → set wins.
- Interrupt priority (IIR[3:0]): 0110 line error (IER[2] & LSR b1..b4); 0100 RX data (IER[0] & count >= threshold); 0010 THRE (IER[1] & thre_pend); 0001 none. IIR[7:6] = 11 when FIFO enabled. irq_o = IIR[0]==0.
- thre_pend: set on rising edge of tx_fifo_empty_i or on IER[1] 0->1 while empty; cleared by THR write or IIR read returning 0010.
- Baud gen: counter loads divisor; baud_out pulses when counter == 1, then reloads. Divisor 0 → baud_out held 0. Any DLL/DLM write reloads counter next cycle.
- Simultaneous wr_i and rd_i: both performed; read returns pre-write value.

## Timing
- Reset values: LCR 0x03, IER/MCR/SCR/FCR 0, divisor 0, sticky bits 0, thre_pend 0, dout_o 0, all strobes/baud_out/irq_o 0, rx_fifo_threshold 1.
- Register write visible in csr the cycle after wr_i.
- dout_o valid one cycle after rd_i; holds until next read.
- Strobes (push/pop) same cycle as access; FIFO reset pulses one cycle after FCR write.
- Divisor N ≥ 1: baud_out period exactly N cycles; N=1 → every cycle.
- rst mid-count: counter and pending state cleared the next edge.

## Structure
- Package uart16550_pkg: address localparams, IIR codes, lcr_t/fcr_t/csr_t structs, threshold decode function.
- Sub-module uart_baud_gen (DIV_W counter, reload, zero-disable).

## Test plan
- Reset, read LCR/IIR/LSR → 0x03, 0x01, 0x60 with both FIFOs empty.
- LCR=0x80, DLL=0x08, DLM=0x01, LCR=0x03 → baud_out every 264 cycles; DLL=0x00, DLM=0 → baud_out stays 0.
- Pulse rx_pe, read LSR → 0x84 (with FIFO empty flags applied); second read → bit2 clear; pulse coinciding with read → bit stays set.
- FCR=0xC1, IER=0x01, count 13 → irq_o 0; count 14 → IIR 0xC4, irq_o 1.
- IER=0x02 with TX empty → IIR 0x02; read IIR → next IIR 0x01; THR write 0x55 → tx_push_o 1 cycle.
- FCR=0x06 → tx_rst and rx_rst single pulses; FCR readback unaffected in IIR.

Source files
------------

// File: rtl/uart16550_pkg.sv
// Shared definitions for the 16550-compatible register block: register
// addresses, interrupt identification codes, register layouts and the RX
// FIFO trigger-level decode.
package uart16550_pkg;

  localparam int unsigned MAX_DIV_W = 24;

  localparam logic [2:0] ADDR_RBR = 3'd0;  // RBR/THR, DLL when DLAB
  localparam logic [2:0] ADDR_IER = 3'd1;  // IER, DLM when DLAB
  localparam logic [2:0] ADDR_IIR = 3'd2;  // IIR read, FCR write
  localparam logic [2:0] ADDR_LCR = 3'd3;
  localparam logic [2:0] ADDR_MCR = 3'd4;
  localparam logic [2:0] ADDR_LSR = 3'd5;
  localparam logic [2:0] ADDR_MSR = 3'd6;
  localparam logic [2:0] ADDR_SCR = 3'd7;

  localparam logic [3:0] IIR_LINE   = 4'b0110;
  localparam logic [3:0] IIR_RXDATA = 4'b0100;
  localparam logic [3:0] IIR_THRE   = 4'b0010;
  localparam logic [3:0] IIR_NONE   = 4'b0001;

  typedef struct packed {
    logic       dlab;
    logic       brk;
    logic       stick;
    logic       eps;
    logic       pen;
    logic       stb;
    logic [1:0] wls;
  } lcr_t;

  // FIFO reset bits are pulses only, so they always read back as zero here.
  typedef struct packed {
    logic [1:0] trig;
    logic [2:0] rsvd;
    logic       tx_rst;
    logic       rx_rst;
    logic       en;
  } fcr_t;

  typedef struct packed {
    lcr_t                 lcr;
    logic [3:0]           ier;
    fcr_t                 fcr;
    logic [4:0]           mcr;
    logic [7:0]           scr;
    logic [MAX_DIV_W-1:0] divisor;
  } csr_t;

  // Trigger level 1/4/8/14 entries, never more than the FIFO can hold.
  function automatic logic [3:0] rx_threshold(input logic [1:0] trig,
                                              input int unsigned depth);
    int unsigned lvl;
    case (trig)
      2'd0:    lvl = 1;
      2'd1:    lvl = 4;
      2'd2:    lvl = 8;
      default: lvl = 14;
    endcase
    if (lvl > depth) lvl = depth;
    return 4'(lvl);
  endfunction

endpackage

// File: rtl/uart16550_csr_baud_gen.sv
// 16x baud pulse generator.
// Ports: clk, rst (sync, active-high), divisor (DIV_W), reload (restart the
// count from divisor), baud_out (one-cycle pulse every divisor cycles,
// held low while divisor is zero).
module uart_baud_gen #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] divisor,
  input  logic             reload,
  output logic             baud_out
);

  logic [DIV_W-1:0] cnt;

  // Count divisor..1; the cycle at 1 emits the pulse and reloads.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      baud_out <= 1'b0;
    end else if (reload || divisor == '0 || cnt == '0) begin
      cnt      <= divisor;
      baud_out <= 1'b0;
    end else if (cnt == DIV_W'(1)) begin
      cnt      <= divisor;
      baud_out <= 1'b1;
    end else begin
      cnt      <= cnt - DIV_W'(1);
      baud_out <= 1'b0;
    end
  end

endmodule

// File: rtl/uart16550_csr.sv
// 16550-compatible control/status register file.
// Ports: host bus (wr_i, rd_i, addr_i, din_i, dout_o registered read data),
// RX/TX FIFO status in (rx_fifo_in, *_empty_i, rx_fifo_count_i), RX error
// pulses (rx_oe/pe/fe/bi), FIFO strobes (tx_push_o, rx_pop_o combinational;
// tx_rst, rx_rst registered pulses), rx_fifo_threshold, baud_out, irq_o and
// the full register image csr for the datapaths.
module uart16550_csr
  import uart16550_pkg::*;
#(
  parameter  int unsigned DIV_W      = 16,
  parameter  int unsigned FIFO_DEPTH = 16,
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_i,
  input  logic             rd_i,
  input  logic [2:0]       addr_i,
  input  logic [7:0]       din_i,
  output logic [7:0]       dout_o,
  input  logic [7:0]       rx_fifo_in,
  input  logic             rx_fifo_empty_i,
  input  logic             tx_fifo_empty_i,
  input  logic [CNT_W-1:0] rx_fifo_count_i,
  input  logic             rx_oe,
  input  logic             rx_pe,
  input  logic             rx_fe,
  input  logic             rx_bi,
  output logic             tx_push_o,
  output logic             rx_pop_o,
  output logic             tx_rst,
  output logic             rx_rst,
  output logic [3:0]       rx_fifo_threshold,
  output logic             baud_out,
  output logic             irq_o,
  output csr_t             csr
);

  lcr_t             lcr;
  logic [3:0]       ier;
  logic             fcr_en;
  logic [1:0]       fcr_trig;
  logic [4:0]       mcr;
  logic [7:0]       scr;
  logic [DIV_W-1:0] divisor;
  logic [3:0]       sticky;      // {bi, fe, pe, oe}
  logic             thre_pend;
  logic             tx_empty_q;
  logic             div_wr_q;

  logic [3:0]       sticky_nx;
  logic [3:0]       iir_code;
  logic [7:0]       lsr;
  logic [7:0]       iir;
  logic [7:0]       rdata;
  logic             thre_set;
  logic             thre_clr;

  // Bus decode, status composition and interrupt prioritisation.
  always_comb begin
    tx_push_o = wr_i && addr_i == ADDR_RBR && !lcr.dlab;
    rx_pop_o  = rd_i && addr_i == ADDR_RBR && !lcr.dlab && !rx_fifo_empty_i;

    lsr = {|sticky, tx_fifo_empty_i, tx_fifo_empty_i, sticky, !rx_fifo_empty_i};

    if (ier[2] && |sticky)
      iir_code = IIR_LINE;
    else if (ier[0] && 32'(rx_fifo_count_i) >= 32'(rx_fifo_threshold))
      iir_code = IIR_RXDATA;
    else if (ier[1] && thre_pend)
      iir_code = IIR_THRE;
    else
      iir_code = IIR_NONE;
    iir = {{2{fcr_en}}, 2'b00, iir_code};

    rdata = '0;
    case (addr_i)
      ADDR_RBR: rdata = lcr.dlab ? divisor[7:0] : (rx_fifo_empty_i ? 8'h00 : rx_fifo_in);
      ADDR_IER: rdata = lcr.dlab ? 8'(divisor[DIV_W-1:8]) : {4'h0, ier};
      ADDR_IIR: rdata = iir;
      ADDR_LCR: rdata = lcr;
      ADDR_MCR: rdata = {3'b000, mcr};
      ADDR_LSR: rdata = lsr;
      ADDR_MSR: rdata = 8'h00;
      default:  rdata = scr;
    endcase

    // A new error arriving with the clearing read survives it.
    sticky_nx = (rd_i && addr_i == ADDR_LSR) ? 4'h0 : sticky;
    sticky_nx = sticky_nx | {rx_bi, rx_fe, rx_pe, rx_oe};

    thre_set = (tx_fifo_empty_i && !tx_empty_q) ||
               (wr_i && addr_i == ADDR_IER && !lcr.dlab && din_i[1] &&
                !ier[1] && tx_fifo_empty_i);
    thre_clr = tx_push_o || (rd_i && addr_i == ADDR_IIR && iir_code == IIR_THRE);
  end

  // Register file and registered strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      lcr               <= lcr_t'(8'h03);
      ier               <= '0;
      fcr_en            <= 1'b0;
      fcr_trig          <= '0;
      mcr               <= '0;
      scr               <= '0;
      divisor           <= '0;
      sticky            <= '0;
      thre_pend         <= 1'b0;
      tx_empty_q        <= 1'b1;
      div_wr_q          <= 1'b0;
      dout_o            <= '0;
      tx_rst            <= 1'b0;
      rx_rst            <= 1'b0;
      irq_o             <= 1'b0;
      rx_fifo_threshold <= 4'd1;
    end else begin
      sticky     <= sticky_nx;
      thre_pend  <= thre_set || (thre_pend && !thre_clr);
      tx_empty_q <= tx_fifo_empty_i;
      irq_o      <= iir_code != IIR_NONE;
      tx_rst     <= wr_i && addr_i == ADDR_IIR && din_i[2];
      rx_rst     <= wr_i && addr_i == ADDR_IIR && din_i[1];
      div_wr_q   <= wr_i && lcr.dlab && (addr_i == ADDR_RBR || addr_i == ADDR_IER);
      if (rd_i) dout_o <= rdata;
      if (wr_i) begin
        case (addr_i)
          ADDR_RBR: if (lcr.dlab) divisor[7:0] <= din_i;
          ADDR_IER: begin
            if (lcr.dlab) divisor[DIV_W-1:8] <= (DIV_W-8)'(din_i);
            else          ier <= din_i[3:0];
          end
          ADDR_IIR: begin
            fcr_en            <= din_i[0];
            fcr_trig          <= din_i[7:6];
            rx_fifo_threshold <= rx_threshold(din_i[7:6], FIFO_DEPTH);
          end
          ADDR_LCR: lcr <= lcr_t'(din_i);
          ADDR_MCR: mcr <= din_i[4:0];
          ADDR_SCR: scr <= din_i;
          default: ;
        endcase
      end
    end
  end

  // Register image for the datapaths.
  always_comb begin
    csr          = '0;
    csr.lcr      = lcr;
    csr.ier      = ier;
    csr.fcr.trig = fcr_trig;
    csr.fcr.en   = fcr_en;
    csr.mcr      = mcr;
    csr.scr      = scr;
    csr.divisor  = MAX_DIV_W'(divisor);
  end

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .divisor  (divisor),
    .reload   (div_wr_q),
    .baud_out (baud_out)
  );

endmodule

// File: tb/tb_uart16550_csr.sv
// Bench for uart16550_csr: directed register scenarios followed by random
// bus/status traffic, all checked against a behavioural register model.
module tb_uart16550_csr;
  import uart16550_pkg::*;

  localparam int unsigned DIV_W      = 16;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst, wr, rd;
  logic [2:0]       addr;
  logic [7:0]       din, dout, rx_data;
  logic             rx_empty, tx_empty;
  logic [CNT_W-1:0] rx_count;
  logic             oe, pe, fe, bi;
  logic             tx_push, rx_pop, tx_rst, rx_rst, baud, irq;
  logic [3:0]       thr_out;
  csr_t             csr;

  always #5 clk = ~clk;

  uart16550_csr #(.DIV_W(DIV_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_i(wr), .rd_i(rd), .addr_i(addr), .din_i(din),
    .dout_o(dout), .rx_fifo_in(rx_data), .rx_fifo_empty_i(rx_empty),
    .tx_fifo_empty_i(tx_empty), .rx_fifo_count_i(rx_count),
    .rx_oe(oe), .rx_pe(pe), .rx_fe(fe), .rx_bi(bi),
    .tx_push_o(tx_push), .rx_pop_o(rx_pop), .tx_rst(tx_rst), .rx_rst(rx_rst),
    .rx_fifo_threshold(thr_out), .baud_out(baud), .irq_o(irq), .csr(csr)
  );

  int n_checks;
  int n_errors;

  // Model state: what the registers must hold after the most recent edge.
  logic [7:0]  m_lcr, m_scr, m_dout;
  logic [3:0]  m_ier, m_st, m_thr;
  logic        m_fen, m_thre, m_txe_prev, m_irq, m_txrst, m_rxrst, m_ok;
  logic [1:0]  m_trig;
  logic [4:0]  m_mcr;
  logic [15:0] m_div;
  int          m_zero_run;
  int          lvl_tab [4] = '{1, 4, 8, 14};

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_lsr();
    return {|m_st, tx_empty, tx_empty, m_st, !rx_empty};
  endfunction

  function automatic logic [3:0] m_code();
    if (m_ier[2] && m_st != 4'h0) return 4'h6;
    if (m_ier[0] && int'(rx_count) >= int'(m_thr)) return 4'h4;
    if (m_ier[1] && m_thre) return 4'h2;
    return 4'h1;
  endfunction

  // Advance the model across the coming edge using the inputs now applied.
  task automatic model_step();
    logic [3:0] code;
    logic [7:0] rv;
    logic       dlab, set_t, clr_t;
    int         lvl;
    if (rst) begin
      m_lcr = 8'h03; m_ier = '0; m_fen = 1'b0; m_trig = '0; m_thr = 4'd1;
      m_mcr = '0; m_scr = '0; m_div = '0; m_st = '0; m_thre = 1'b0;
      m_txe_prev = 1'b1; m_dout = '0; m_irq = 1'b0; m_txrst = 1'b0;
      m_rxrst = 1'b0; m_zero_run = 2; m_ok = 1'b1;
      return;
    end
    dlab = m_lcr[7];
    code = m_code();
    if (rd) begin
      case (addr)
        3'd0:    rv = dlab ? m_div[7:0] : (rx_empty ? 8'h00 : rx_data);
        3'd1:    rv = dlab ? m_div[15:8] : {4'h0, m_ier};
        3'd2:    rv = {m_fen, m_fen, 2'b00, code};
        3'd3:    rv = m_lcr;
        3'd4:    rv = {3'b000, m_mcr};
        3'd5:    rv = m_lsr();
        3'd6:    rv = 8'h00;
        default: rv = m_scr;
      endcase
      m_dout = rv;
    end
    m_irq   = code != 4'h1;
    m_txrst = wr && addr == 3'd2 && din[2];
    m_rxrst = wr && addr == 3'd2 && din[1];
    set_t = (tx_empty && !m_txe_prev) ||
            (wr && addr == 3'd1 && !dlab && din[1] && !m_ier[1] && tx_empty);
    clr_t = (wr && addr == 3'd0 && !dlab) || (rd && addr == 3'd2 && code == 4'h2);
    if (rd && addr == 3'd5) m_st = 4'h0;
    m_st       = m_st | {bi, fe, pe, oe};
    m_thre     = set_t || (m_thre && !clr_t);
    m_txe_prev = tx_empty;
    if (wr) begin
      case (addr)
        3'd0: if (dlab) m_div[7:0] = din;
        3'd1: if (dlab) m_div[15:8] = din; else m_ier = din[3:0];
        3'd2: begin
          m_fen = din[0]; m_trig = din[7:6];
          lvl = lvl_tab[m_trig];
          if (lvl > int'(FIFO_DEPTH)) lvl = int'(FIFO_DEPTH);
          m_thr = 4'(lvl);
        end
        3'd3: m_lcr = din;
        3'd4: m_mcr = din[4:0];
        3'd7: m_scr = din;
        default: ;
      endcase
    end
    m_zero_run = (m_div == 16'h0) ? m_zero_run + 1 : 0;
  endtask

  // Compare every cycle on the falling edge, then step the model.
  task automatic monitor();
    csr_t e;
    forever begin
      @(negedge clk);
      if (m_ok) begin
        chk("tx_push", 64'(tx_push), 64'(wr && addr == 3'd0 && !m_lcr[7]));
        chk("rx_pop", 64'(rx_pop), 64'(rd && addr == 3'd0 && !m_lcr[7] && !rx_empty));
        chk("dout", 64'(dout), 64'(m_dout));
        chk("irq", 64'(irq), 64'(m_irq));
        chk("tx_rst", 64'(tx_rst), 64'(m_txrst));
        chk("rx_rst", 64'(rx_rst), 64'(m_rxrst));
        chk("threshold", 64'(thr_out), 64'(m_thr));
        e = '0;
        e.lcr = lcr_t'(m_lcr); e.ier = m_ier; e.fcr.trig = m_trig; e.fcr.en = m_fen;
        e.mcr = m_mcr; e.scr = m_scr; e.divisor = 24'(m_div);
        chk("csr", 64'(csr), 64'(e));
        if (m_zero_run >= 2) chk("baud_off", 64'(baud), 64'd0);
      end
      model_step();
    end
  endtask

  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_wr(input logic [2:0] a, input logic [7:0] d);
    wr = 1'b1; addr = a; din = d;
    step_cycle();
    wr = 1'b0;
  endtask

  task automatic do_rd(input logic [2:0] a, output logic [7:0] v);
    rd = 1'b1; addr = a;
    step_cycle();
    rd = 1'b0;
    v = dout;
  endtask

  // Time three baud pulses and check the spacing of the last two.
  task automatic measure(input int n, input string name);
    int t;
    int edges[$];
    t = 0;
    while (edges.size() < 3 && t < 3 * n + 20) begin
      step_cycle();
      t++;
      if (baud) edges.push_back(t);
    end
    if (edges.size() < 3) chk({name, "_timeout"}, 64'(edges.size()), 64'd3);
    else chk(name, 64'(edges[2] - edges[1]), 64'(n));
  endtask

  logic [7:0] v;
  int         pulses;

  initial begin
    n_checks = 0; n_errors = 0; m_ok = 1'b0;
    rst = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; din = '0; rx_data = '0;
    rx_empty = 1'b1; tx_empty = 1'b1; rx_count = '0;
    oe = 1'b0; pe = 1'b0; fe = 1'b0; bi = 1'b0;
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    do_rd(3'd3, v); chk("rst_lcr", 64'(v), 64'h03);
    do_rd(3'd2, v); chk("rst_iir", 64'(v), 64'h01);
    do_rd(3'd5, v); chk("rst_lsr", 64'(v), 64'h60);

    do_wr(3'd3, 8'h80); do_wr(3'd0, 8'h08); do_wr(3'd1, 8'h01); do_wr(3'd3, 8'h03);
    measure(264, "baud_264");
    do_wr(3'd3, 8'h80); do_wr(3'd0, 8'h01); do_wr(3'd1, 8'h00); do_wr(3'd3, 8'h03);
    measure(1, "baud_1");
    do_wr(3'd3, 8'h80); do_wr(3'd0, 8'h05); do_wr(3'd3, 8'h03);
    measure(5, "baud_5");
    do_wr(3'd3, 8'h80); do_wr(3'd0, 8'h00); do_wr(3'd1, 8'h00); do_wr(3'd3, 8'h03);
    pulses = 0;
    repeat (600) begin step_cycle(); if (baud) pulses++; end
    chk("baud_zero", 64'(pulses), 64'd0);

    tx_empty = 1'b0; step_cycle();
    pe = 1'b1; step_cycle(); pe = 1'b0;
    do_rd(3'd5, v); chk("lsr_pe", 64'(v), 64'h84);
    do_rd(3'd5, v); chk("lsr_cleared", 64'(v), 64'h00);
    pe = 1'b1; do_rd(3'd5, v); pe = 1'b0;
    chk("lsr_coincide_rd", 64'(v), 64'h00);
    do_rd(3'd5, v); chk("lsr_set_wins", 64'(v), 64'h84);
    tx_empty = 1'b1; step_cycle();

    do_wr(3'd2, 8'hC1); do_wr(3'd1, 8'h01);
    rx_count = CNT_W'(13); repeat (2) step_cycle();
    chk("irq_below", 64'(irq), 64'd0);
    chk("thr_14", 64'(thr_out), 64'd14);
    rx_count = CNT_W'(14); repeat (2) step_cycle();
    chk("irq_at", 64'(irq), 64'd1);
    do_rd(3'd2, v); chk("iir_rx", 64'(v), 64'hC4);
    rx_count = '0; do_wr(3'd1, 8'h00); do_wr(3'd2, 8'h00);

    do_wr(3'd1, 8'h02);
    do_rd(3'd2, v); chk("iir_thre", 64'(v), 64'h02);
    do_rd(3'd2, v); chk("iir_after_rd", 64'(v), 64'h01);
    wr = 1'b1; addr = 3'd0; din = 8'h55;
    #1 chk("push_on", 64'(tx_push), 64'd1);
    step_cycle(); wr = 1'b0;
    #1 chk("push_off", 64'(tx_push), 64'd0);
    do_wr(3'd1, 8'h00);

    do_wr(3'd2, 8'h06);
    chk("tx_rst_pulse", 64'(tx_rst), 64'd1);
    chk("rx_rst_pulse", 64'(rx_rst), 64'd1);
    step_cycle();
    chk("tx_rst_end", 64'(tx_rst), 64'd0);
    chk("rx_rst_end", 64'(rx_rst), 64'd0);
    do_rd(3'd2, v); chk("iir_after_fcr", 64'(v), 64'h01);

    do_wr(3'd7, 8'hA5); do_rd(3'd7, v); chk("scr", 64'(v), 64'hA5);
    do_wr(3'd4, 8'hFF); do_rd(3'd4, v); chk("mcr", 64'(v), 64'h1F);
    do_rd(3'd6, v); chk("msr", 64'(v), 64'h00);
    rx_empty = 1'b0; rx_data = 8'h3C;
    do_rd(3'd0, v); chk("rbr", 64'(v), 64'h3C);
    rx_empty = 1'b1;
    do_rd(3'd0, v); chk("rbr_empty", 64'(v), 64'h00);

    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 499) == 0);
      wr       = !rst && ($urandom_range(0, 2) == 0);
      rd       = !rst && ($urandom_range(0, 2) == 0);
      addr     = 3'($urandom_range(0, 7));
      din      = 8'($urandom);
      if ($urandom_range(0, 7) == 0) tx_empty = ~tx_empty;
      rx_empty = ($urandom_range(0, 3) == 0);
      rx_count = CNT_W'($urandom_range(0, FIFO_DEPTH));
      rx_data  = 8'($urandom);
      oe = ($urandom_range(0, 15) == 0);
      pe = ($urandom_range(0, 15) == 0);
      fe = ($urandom_range(0, 15) == 0);
      bi = ($urandom_range(0, 15) == 0);
      step_cycle();
    end
    rst = 1'b0; wr = 1'b0; rd = 1'b0; oe = 1'b0; pe = 1'b0; fe = 1'b0; bi = 1'b0;
    repeat (4) step_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
